// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types and constants for the WISC pipeline control unit.
//
// Contents:
//   ST_IF..ST_WB  stage index constants for the 5-stage pipeline
//   sb_entry_t    one scoreboard slot: {vld, wen, rd, load}
//   halt_st_e     halt FSM encoding (RUN / DRAIN / HALTED)
//   act_e         which stall source is acting this cycle
//   sel_src()     fixed-priority pick of the acting source
package pipe_pkg;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EX  = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  // rd is sized for the widest supported register file (RW <= RD_W).
  // Narrower register addresses are zero-extended into it.
  localparam int RD_W = 8;

  typedef struct packed {
    logic            vld;
    logic            wen;
    logic [RD_W-1:0] rd;
    logic            load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_HALTED = 2'd2
  } halt_st_e;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_HALTED = 3'd1,
    ACT_MEM    = 3'd2,
    ACT_DRAIN  = 3'd3,
    ACT_REDIR  = 3'd4,
    ACT_RAW    = 3'd5,
    ACT_IF     = 3'd6
  } act_e;

  // Exactly one source acts per cycle. HALTED overrides everything; a dmem
  // stall still acts while draining (it holds the drain countdown), while
  // redirect/raw/if_busy only matter in RUN.
  function automatic act_e sel_src(input logic [1:0] st,
                                   input logic mem_busy,
                                   input logic redirect,
                                   input logic raw,
                                   input logic if_busy);
    act_e a;
    if (st == HS_HALTED)     a = ACT_HALTED;
    else if (mem_busy)       a = ACT_MEM;
    else if (st == HS_DRAIN) a = ACT_DRAIN;
    else if (redirect)       a = ACT_REDIR;
    else if (raw)            a = ACT_RAW;
    else if (if_busy)        a = ACT_IF;
    else                     a = ACT_NONE;
    return a;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- bundle between the pipeline datapath and pipe_ctrl.
//
// ID-stage info : id_valid, id_rs_a/b, id_use_a/b, id_wen, id_rd, id_load, id_halt
// Stall sources : if_busy, mem_busy, redirect
// Controls      : freeze[NSTAGE-2:0] (bit 0 = PC hold, bit b = hold boundary b)
//                 bubble[NSTAGE-1:0] (bit b = NOP into boundary b, bit 0 unused)
// Status        : stall_raw, halted, stall_cnt
// master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int RW     = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [RW-1:0]     id_rs_a;
  logic [RW-1:0]     id_rs_b;
  logic              id_use_a;
  logic              id_use_b;
  logic              id_wen;
  logic [RW-1:0]     id_rd;
  logic              id_load;
  logic              id_halt;
  logic              if_busy;
  logic              mem_busy;
  logic              redirect;
  logic [NSTAGE-2:0] freeze;
  logic [NSTAGE-1:0] bubble;
  logic              stall_raw;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_wen, id_rd,
           id_load, id_halt, if_busy, mem_busy, redirect,
    input  freeze, bubble, stall_raw, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_wen, id_rd,
           id_load, id_halt, if_busy, mem_busy, redirect,
    output freeze, bubble, stall_raw, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard -- shadow copy of destination info for stages
// REDIR_STAGE..NSTAGE-1, plus RAW match against the ID sources.
//
// Ports:
//   clk, rst          clock, async active-low reset
//   hold              dmem stall: stages up to LOAD_STAGE keep their entry,
//                     LOAD_STAGE+1 takes an empty slot
//   push, ins         entry loaded into REDIR_STAGE when ID advances
//   src_vld, use_*,
//   rs_*              ID instruction sources
//   raw               combinational RAW hazard
//
// Build option: PIPE_CTRL_FWD_EN (defined = forwarding, only load-use stalls).
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NSTAGE      = 5,
  parameter int RW          = 3,
  parameter int LOAD_STAGE  = 3,
  parameter int REDIR_STAGE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          push,
  input  sb_entry_t     ins,
  input  logic          src_vld,
  input  logic          use_a,
  input  logic          use_b,
  input  logic [RW-1:0] rs_a,
  input  logic [RW-1:0] rs_b,
  output logic          raw
);

  // slot i tracks stage REDIR_STAGE+i
  localparam int NE = NSTAGE - REDIR_STAGE;

  sb_entry_t [NE-1:0] sb_q, sb_d;
  logic      [NE-1:0] hit;

  always_comb begin
    sb_d[0] = push ? ins : SB_EMPTY;
    for (int i = 1; i < NE; i++) sb_d[i] = sb_q[i-1];
    if (hold) begin
      for (int i = 0; i < NE; i++) begin
        if (i + REDIR_STAGE <= LOAD_STAGE)          sb_d[i] = sb_q[i];
        else if (i + REDIR_STAGE == LOAD_STAGE + 1) sb_d[i] = SB_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= sb_d;
  end

  for (genvar i = 0; i < NE; i++) begin : g_match
    localparam int STG = REDIR_STAGE + i;
    logic src_hit;
    assign src_hit = sb_q[i].vld && sb_q[i].wen &&
                     ((use_a && sb_q[i].rd == RD_W'(rs_a)) ||
                      (use_b && sb_q[i].rd == RD_W'(rs_b)));
`ifdef PIPE_CTRL_FWD_EN
    // forwarded ALU results are free; a load's data only exists past LOAD_STAGE
    assign hit[i] = src_hit && sb_q[i].load && (STG < LOAD_STAGE);
`else
    // no bypass: wait until the writer is in WB (RF writes before read)
    logic unused_ld;
    assign unused_ld = sb_q[i].load;
    assign hit[i]    = src_hit && (STG <= NSTAGE - 2);
`endif
  end

  assign raw = src_vld && (|hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control for the in-order WISC pipeline.
// Tracks in-flight writers, detects RAW hazards, arbitrates stall sources
// (dmem, redirect, RAW, imem, halt drain) and drives per-boundary
// freeze/bubble controls plus a saturating stall counter.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  pipe_ctrl_if.slave (ID info, stall sources, controls, status)
//
// Build option: PIPE_CTRL_FWD_EN -- forwarding present, only load-use
// stalls; undefined, any in-flight writer short of WB stalls the reader.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE      = 5,
  parameter int RW          = 3,
  parameter int LOAD_STAGE  = 3,
  parameter int REDIR_STAGE = 2,
  parameter int CNT_W       = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN    = HS_RUN;
  localparam logic [1:0] S_DRAIN  = HS_DRAIN;
  localparam logic [1:0] S_HALTED = HS_HALTED;

  // drain covers the instructions still ahead of the HALT
  localparam int              DC_W       = $clog2(NSTAGE);
  localparam logic [DC_W-1:0] DRAIN_INIT = DC_W'(NSTAGE - 2);

  // PC and every boundary up to the load stage hold on a dmem stall
  localparam logic [NSTAGE-2:0] FRZ_MEM = (NSTAGE-1)'((1 << (LOAD_STAGE + 1)) - 1);

  logic [1:0]       state_q, state_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic      raw;
  logic      adv;
  logic      sb_hold;
  sb_entry_t ins;
  act_e      act;

  // ID moves into EX only when nothing blocks it
  assign adv     = (state_q == S_RUN) && !raw && !bus.redirect && !bus.mem_busy;
  assign sb_hold = bus.mem_busy && (state_q != S_HALTED);

  always_comb begin
    ins      = SB_EMPTY;
    ins.vld  = bus.id_valid;
    ins.wen  = bus.id_wen;
    ins.rd   = RD_W'(bus.id_rd);
    ins.load = bus.id_load;
  end

  pipe_scoreboard #(
    .NSTAGE      (NSTAGE),
    .RW          (RW),
    .LOAD_STAGE  (LOAD_STAGE),
    .REDIR_STAGE (REDIR_STAGE)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .hold    (sb_hold),
    .push    (adv),
    .ins     (ins),
    .src_vld (bus.id_valid),
    .use_a   (bus.id_use_a),
    .use_b   (bus.id_use_b),
    .rs_a    (bus.id_rs_a),
    .rs_b    (bus.id_rs_b),
    .raw     (raw)
  );

  assign act = sel_src(state_q, bus.mem_busy, bus.redirect, raw, bus.if_busy);

  always_comb begin
    bus.freeze    = '0;
    bus.bubble    = '0;
    bus.stall_raw = 1'b0;
    case (act)
      ACT_HALTED: bus.freeze = '1;
      ACT_MEM: begin
        bus.freeze                 = FRZ_MEM;
        bus.bubble[LOAD_STAGE + 1] = 1'b1;
      end
      ACT_DRAIN: begin
        bus.freeze[ST_IF] = 1'b1;
        bus.bubble[ST_ID] = 1'b1;
        bus.bubble[ST_EX] = 1'b1;
      end
      ACT_REDIR: begin
        // PC keeps moving so fetch picks up the new target
        bus.bubble[ST_ID] = 1'b1;
        bus.bubble[ST_EX] = 1'b1;
      end
      ACT_RAW: begin
        bus.freeze[ST_IF] = 1'b1;
        bus.freeze[ST_ID] = 1'b1;
        bus.bubble[ST_EX] = 1'b1;
        bus.stall_raw     = 1'b1;
      end
      ACT_IF: begin
        bus.freeze[ST_IF] = 1'b1;
        bus.bubble[ST_ID] = 1'b1;
      end
      default: ;
    endcase
  end

  // halt FSM; a redirect blocks adv, which is what squashes a HALT in ID
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_RUN: begin
        if (adv && bus.id_valid && bus.id_halt) begin
          state_d = S_DRAIN;
          dcnt_d  = DRAIN_INIT;
        end
      end
      S_DRAIN: begin
        if (!bus.mem_busy) begin
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q == DC_W'(1)) state_d = S_HALTED;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    if ((act == ACT_MEM || act == ACT_RAW || act == ACT_IF) && !(&scnt_q))
      scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      dcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus.halted    = (state_q == S_HALTED);
  assign bus.stall_cnt = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed scenarios plus randomized traffic against a
// reference model that tracks in-flight writers as a list of
// {stage, rd, load} records and applies the stall rules directly.
module tb_pipe_ctrl;
  localparam int NSTAGE     = 5;
  localparam int RW         = 3;
  localparam int LOAD_STAGE = 3;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGE(NSTAGE), .RW(RW), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.NSTAGE(NSTAGE), .RW(RW), .LOAD_STAGE(LOAD_STAGE),
              .REDIR_STAGE(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int stg; logic [RW-1:0] rd; bit ld;} wr_t;
  typedef enum {M_NONE, M_HALT, M_MEM, M_DRAIN, M_REDIR, M_RAW, M_IF} mode_t;

  wr_t   fly[$];
  bit    m_drain, m_halted, m_raw;
  int    m_left, m_cnt;
  mode_t mode;

  task automatic m_eval();
    m_raw = 1'b0;
    if (bus.id_valid) begin
      foreach (fly[k]) begin
        bit src, stalls;
        src = (bus.id_use_a && bus.id_rs_a == fly[k].rd) ||
              (bus.id_use_b && bus.id_rs_b == fly[k].rd);
        stalls = FWD ? (fly[k].ld && fly[k].stg < LOAD_STAGE)
                     : (fly[k].stg < NSTAGE - 1);
        if (src && stalls) m_raw = 1'b1;
      end
    end
    if (m_halted)          mode = M_HALT;
    else if (bus.mem_busy) mode = M_MEM;
    else if (m_drain)      mode = M_DRAIN;
    else if (bus.redirect) mode = M_REDIR;
    else if (m_raw)        mode = M_RAW;
    else if (bus.if_busy)  mode = M_IF;
    else                   mode = M_NONE;
  endtask

  task automatic m_check(input string ph);
    logic [3:0] ef;
    logic [4:0] eb;
    case (mode)
      M_HALT:  begin ef = 4'b1111; eb = 5'b00000; end
      M_MEM:   begin ef = 4'b1111; eb = 5'b10000; end
      M_DRAIN: begin ef = 4'b0001; eb = 5'b00110; end
      M_REDIR: begin ef = 4'b0000; eb = 5'b00110; end
      M_RAW:   begin ef = 4'b0011; eb = 5'b00100; end
      M_IF:    begin ef = 4'b0001; eb = 5'b00010; end
      default: begin ef = 4'b0000; eb = 5'b00000; end
    endcase
    chk({ph, ".freeze"},    bus.freeze,    ef);
    chk({ph, ".bubble"},    bus.bubble,    eb);
    chk({ph, ".stall_raw"}, bus.stall_raw, (mode == M_RAW));
    chk({ph, ".halted"},    bus.halted,    m_halted);
    chk({ph, ".stall_cnt"}, bus.stall_cnt, m_cnt);
  endtask

  task automatic m_step();
    bit  adv, memact;
    wr_t nf[$];
    adv    = !m_drain && !m_halted && !m_raw && !bus.redirect && !bus.mem_busy;
    memact = bus.mem_busy && !m_halted;
    foreach (fly[k]) begin
      wr_t r;
      r = fly[k];
      if (!(memact && r.stg <= LOAD_STAGE)) r.stg++;
      if (r.stg <= NSTAGE - 1) nf.push_back(r);
    end
    if (adv && bus.id_valid && bus.id_wen) nf.push_back('{2, bus.id_rd, bus.id_load});
    fly = nf;
    if ((mode == M_MEM || mode == M_RAW || mode == M_IF) && m_cnt < CNT_MAX) m_cnt++;
    if (m_drain) begin
      if (!bus.mem_busy) begin
        m_left--;
        if (m_left == 0) begin m_drain = 1'b0; m_halted = 1'b1; end
      end
    end else if (adv && bus.id_valid && bus.id_halt) begin
      m_drain = 1'b1;
      m_left  = NSTAGE - 2;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.id_valid = 0; bus.id_rs_a = 0; bus.id_rs_b = 0; bus.id_use_a = 0;
    bus.id_use_b = 0; bus.id_wen = 0; bus.id_rd = 0; bus.id_load = 0;
    bus.id_halt = 0; bus.if_busy = 0; bus.mem_busy = 0; bus.redirect = 0;
  endtask

  task automatic ins(input bit we, input logic [RW-1:0] rd, input bit ld,
                     input bit ua, input logic [RW-1:0] ra, input bit hl);
    bus.id_valid = 1; bus.id_wen = we; bus.id_rd = rd; bus.id_load = ld;
    bus.id_use_a = ua; bus.id_rs_a = ra; bus.id_use_b = 0; bus.id_rs_b = 0;
    bus.id_halt = hl;
  endtask

  task automatic evt(input bit ifb, input bit mb, input bit rdr);
    bus.if_busy = ifb; bus.mem_busy = mb; bus.redirect = rdr;
  endtask

  // called just after a falling edge; inputs must already be set
  task automatic cyc(input string ph);
    #1;
    m_eval();
    m_check(ph);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    #1;
    chk("rst.freeze",    bus.freeze,    0);
    chk("rst.bubble",    bus.bubble,    0);
    chk("rst.stall_raw", bus.stall_raw, 0);
    chk("rst.halted",    bus.halted,    0);
    chk("rst.stall_cnt", bus.stall_cnt, 0);
    fly.delete();
    m_drain = 0; m_halted = 0; m_left = 0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int halt_age;

  initial begin
    do_reset();

    // load (or ALU) producer followed by a consumer of the same register
    ins(1, 3'd3, 1, 0, 0, 0); cyc("t1.ld");
    ins(1, 3'd5, 0, 1, 3'd3, 0);
    #1 chk("t1.raw0", bus.stall_raw, 1); chk("t1.frz0", bus.freeze, 4'b0011);
    cyc("t1.c0");
    #1 chk("t1.raw1", bus.stall_raw, FWD ? 0 : 1);
    cyc("t1.c1");
    cyc("t1.c2");
    ins(1, 3'd2, 0, 0, 0, 0); cyc("t2.add");
    ins(1, 3'd6, 0, 1, 3'd2, 0);
    #1 chk("t2.raw0", bus.stall_raw, FWD ? 0 : 1);
    cyc("t2.c0"); cyc("t2.c1");
    #1 chk("t2.rel", bus.stall_raw, 0);
    cyc("t2.c2");

    // dmem stall covering a pending RAW
    do_reset();
    ins(1, 3'd3, 1, 0, 0, 0); cyc("t3.ld");
    ins(1, 3'd4, 0, 1, 3'd3, 0); evt(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3.frz", bus.freeze, 4'b1111); chk("t3.bub", bus.bubble, 5'b10000);
      chk("t3.raw", bus.stall_raw, 0);
      cyc("t3.mb");
    end
    evt(0, 0, 0);
    #1 chk("t3.raw_back", bus.stall_raw, 1); chk("t3.cnt", bus.stall_cnt, 3);
    cyc("t3.after");

    // redirect beats raw and squashes HALT
    do_reset();
    ins(1, 3'd3, 1, 0, 0, 0); cyc("t4.ld");
    ins(0, 3'd0, 0, 1, 3'd3, 1); evt(0, 0, 1);
    #1 chk("t4.frz", bus.freeze, 0); chk("t4.bub", bus.bubble, 5'b00110);
    cyc("t4.rdr");
    idle();
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4.run", bus.freeze, 0);
      cyc("t4.idle");
    end

    // HALT drain with one dmem stall interleaved
    do_reset();
    ins(0, 3'd0, 0, 0, 0, 1); cyc("t5.halt");
    idle();
    for (int i = 0; i < 4; i++) begin
      evt(0, (i == 1), 0);
      #1 chk("t5.draining", bus.halted, 0);
      cyc("t5.drain");
    end
    evt(0, 0, 0);
    #1 chk("t5.halted", bus.halted, 1); chk("t5.frz", bus.freeze, 4'b1111);
    cyc("t5.h");
    do_reset();

    // counter saturation
    idle(); evt(1, 0, 0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc("t6.ifb");
    #1 chk("t6.sat", bus.stall_cnt, CNT_MAX);
    do_reset();

    // randomized traffic
    halt_age = 0;
    for (int n = 0; n < 2000; n++) begin
      if (halt_age > 2 || $urandom_range(0, 399) == 0) begin
        do_reset();
        halt_age = 0;
      end
      bus.id_valid = ($urandom_range(0, 9) < 8);
      bus.id_rs_a  = RW'($urandom);
      bus.id_rs_b  = RW'($urandom);
      bus.id_use_a = $urandom_range(0, 1);
      bus.id_use_b = $urandom_range(0, 1);
      bus.id_wen   = ($urandom_range(0, 3) != 0);
      bus.id_rd    = RW'($urandom);
      bus.id_load  = ($urandom_range(0, 2) == 0);
      bus.id_halt  = ($urandom_range(0, 59) == 0);
      bus.if_busy  = ($urandom_range(0, 6) == 0);
      bus.mem_busy = ($urandom_range(0, 9) == 0);
      bus.redirect = ($urandom_range(0, 11) == 0);
      cyc("rnd");
      if (m_halted) halt_age++;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the in-order WISC pipeline (IF, ID, EX, MEM, WB).
- Replaces the single-purpose load-use hazard unit.
- Keeps a shadow scoreboard of in-flight destination registers and detects RAW hazards.
- Arbitrates stall sources (multi-cycle imem/dmem, branch redirect, RAW, halt drain).
- Drives per-boundary freeze/bubble vectors into the IF/ID, ID/EX, EX/MEM and MEM/WB flops and the PC.

Parameters:
NSTAGE, 5, pipeline depth; stage 0 is IF, stage NSTAGE-1 is WB
RW, 3, register-address width
LOAD_STAGE, 3, stage whose output carries load data (MEM)
REDIR_STAGE, 2, stage that resolves branches/jumps (EX)
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
id_valid  in  1  ID holds a real instruction
id_rs_a, id_rs_b  in  RW  ID source registers
id_use_a, id_use_b  in  1  source actually read
id_wen  in  1  ID instruction writes RF
id_rd  in  RW  ID destination
id_load  in  1  ID instruction is a load
id_halt  in  1  ID instruction is HALT
if_busy  in  1  imem not ready this cycle
mem_busy  in  1  dmem not ready this cycle
redirect  in  1  REDIR_STAGE resolved a taken control transfer
freeze  out  NSTAGE-1  freeze[0]=PC hold; freeze[b]=hold boundary register b (feeds stage b), b=1..NSTAGE-2
bubble  out  NSTAGE  bubble[b]=load NOP into boundary b, b=1..NSTAGE-1; bit 0 unused, tied 0
stall_raw  out  1  RAW stall this cycle
halted  out  1  pipeline drained after HALT
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: entries for stages REDIR_STAGE..NSTAGE-1, each {valid, wen, rd, load}. Reset clears every entry.
- Scoreboard advance rule, each edge:
  - Entries shift one stage.
  - ID info enters stage 2 only when ID advances (no raw, no redirect, no mem_busy, state RUN).
  - Otherwise stage 2 receives an invalid entry.
  - The entry leaving WB is dropped.
- Under mem_busy, stages 0..LOAD_STAGE hold and stage LOAD_STAGE+1 receives invalid.
- RAW hazard, computed combinationally: for each used source matching a valid wen entry rd:
  - with forwarding, hazard if entry.load and stage < LOAD_STAGE;
  - without forwarding, hazard if stage <= NSTAGE-2.
  - WB-stage matches never stall; the RF bypasses write-before-read.
  - Register 0 is an ordinary register.
- Priority, highest first; each output bit not listed is 0:
  1. mem_busy: freeze[0..LOAD_STAGE]=1, bubble[LOAD_STAGE+1]=1.
  2. redirect: bubble[1]=bubble[2]=1. PC not frozen, so fetch takes the new target.
  3. raw: freeze[0]=freeze[1]=1, bubble[2]=1, stall_raw=1.
  4. if_busy: freeze[0]=1, bubble[1]=1.
- Simultaneous events: only the highest source acts. A lower source is re-evaluated next cycle.
- Halt FSM: RUN, DRAIN, HALTED.
  - RUN to DRAIN when id_valid & id_halt and ID advances. Load drain counter = NSTAGE-2.
  - Redirect in the same cycle squashes the HALT; stay in RUN.
  - DRAIN: freeze[0]=1, bubble[1]=bubble[2]=1. Counter decrements on cycles without mem_busy. At 0, go to HALTED.
  - HALTED: freeze all bits 1, bubble all 0, halted=1. Only reset exits.
- stall_cnt:
  - Increments on any cycle with mem_busy, raw, or if_busy acting (redirect and DRAIN are not counted).
  - Saturates at all-ones; no wrap.
- Reset values: freeze=0, bubble=0, stall_raw=0, halted=0, stall_cnt=0, state RUN, scoreboard empty.
  - Outputs are combinational from state and inputs, so with empty state they follow the inputs.
  - Reset mid-operation discards all scoreboard state immediately.

Optional Feature:
- Macro PIPE_CTRL_FWD_EN.
  - Defined: forwarding datapaths exist; only load-use (load in stage < LOAD_STAGE) stalls.
  - Undefined: no forwarding; any matching writer in EX..NSTAGE-2 stalls until it reaches WB.
- Port list is identical in both builds.

Decomposition:
- Package pipe_pkg: stage index constants (ST_IF..ST_WB), scoreboard entry struct type sb_entry_t, halt-state enum, priority encoding.
- Natural sub-module: pipe_scoreboard (shift register plus match logic, outputs hazard bit).
- FSM, arbitration and counter stay in pipe_ctrl.

Test Plan:
1. Load-use, FWD_EN defined: LD r3 enters EX, ID uses r3 -> stall_raw=1 one cycle, freeze=0b0011, bubble[2]=1, then advance. ADD r3 producer instead -> no stall.
2. FWD_EN undefined: ADD r2 then dependent SUB reading r2 -> stall_raw for 2 cycles (producer in EX, then MEM), release when producer in WB.
3. mem_busy held 3 cycles while raw pending -> freeze[0..3]=1, bubble[4]=1, stall_raw=0 for those cycles, stall_cnt +3; raw stall reappears afterward.
4. Redirect coincident with raw and ID HALT -> bubble[1]=bubble[2]=1, freeze=0, state stays RUN, HALT squashed.
5. HALT with NSTAGE=5 -> DRAIN for 3 cycles (4 if one mem_busy cycle interleaved), then halted=1, freeze all 1; assert rst=0 -> all outputs 0 next sample.
6. Force 2^CNT_W+5 if_busy cycles with CNT_W=4 -> stall_cnt sticks at 15.
